// File: rtl/adc_sched_pkg.sv
// Shared definitions for the paired ADC scheduler: widths, FSM state
// encodings, per-channel bookkeeping record and the raw-to-code conversion.
package adc_sched_pkg;

    localparam int ADC_W  = 16;
    localparam int CODE_W = 12;

    // Scheduler states; plain constants so legacy tools can consume them.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACK     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    // Everything the scheduler remembers about one ADC channel.
    typedef struct packed {
        logic              enable;  // drives the converter enable pin
        logic              done;    // result captured in the current conversion
        logic [CODE_W-1:0] code;    // last captured, clamped code
    } chan_t;

    // Two's-complement ADC word to an unsigned 12-bit code: negative values
    // clamp to zero, otherwise keep the top 12 magnitude bits (0x7FFF -> 0xFFF).
    function automatic logic [CODE_W-1:0] adc_to_code(input logic [ADC_W-1:0] data);
        logic [CODE_W-1:0] code;
        if (data[ADC_W-1]) begin
            code = '0;
        end else begin
            code = data[ADC_W-2 -: CODE_W];
        end
        return code;
    endfunction

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit event counter that sticks at 255; cleared only by the async reset.
module sat_cnt8 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       inc_i,
    output logic [7:0] cnt_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: step on request unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/adc_pair_sched.sv
// Runs both I2C ADC front-ends once per modulator trigger: enables them
// together, waits for both to go busy (ready low), captures each result as
// it appears, and reports one end-of-conversion pulse. A per-conversion
// timeout and saturating error/overrun counters keep a stuck bus from
// stalling the control loop.
//
// ADC handshake: a converter is enabled by the scheduler; it signals that it
// has started by pulling ready low and signals a valid result by raising
// ready again. Only a ready-high that follows a ready-low seen by the
// scheduler (both channels low in the same cycle) is treated as data; a
// ready that is still high from a previous conversion is ignored.
module adc_pair_sched
    import adc_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 54000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              adc1_ready_i,
    input  logic [ADC_W-1:0]  adc1_data_i,
    output logic              adc1_enable_o,
    input  logic              adc2_ready_i,
    input  logic [ADC_W-1:0]  adc2_data_i,
    output logic              adc2_enable_o,
    output logic [CODE_W-1:0] v_fc_o,
    output logic [CODE_W-1:0] v_out_o,
    output logic              eoc_o,
    output logic              busy_o,
    output logic              timeout_o,
    output logic [7:0]        err_cnt_o,
    output logic [7:0]        overrun_cnt_o
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state_q,   state_d;
    logic [TO_W-1:0] to_cnt_q,  to_cnt_d;
    chan_t           ch1_q,     ch1_d;
    chan_t           ch2_q,     ch2_d;
    logic            eoc_q,     eoc_d;
    logic            timeout_q, timeout_d;
    logic            busy_q,    busy_d;
    logic            err_inc;
    logic            ovr_inc;
    logic            to_hit;

    // The conversion window closes on the last allowed cycle.
    assign to_hit = (to_cnt_q == TO_LAST);

    // Scheduler next-state: start, busy-acknowledge, per-channel capture, abort.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        ch1_d     = ch1_q;
        ch2_d     = ch2_q;
        eoc_d     = 1'b0;
        timeout_d = 1'b0;
        err_inc   = 1'b0;
        ovr_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d      = ST_ACK;
                    to_cnt_d     = '0;
                    ch1_d.enable = 1'b1;
                    ch1_d.done   = 1'b0;
                    ch2_d.enable = 1'b1;
                    ch2_d.done   = 1'b0;
                end
            end

            ST_ACK: begin
                ovr_inc = start_i;
                if (to_hit) begin
                    state_d      = ST_IDLE;
                    ch1_d.enable = 1'b0;
                    ch2_d.enable = 1'b0;
                    timeout_d    = 1'b1;
                    err_inc      = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (!adc1_ready_i && !adc2_ready_i) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end

            ST_CAPTURE: begin
                ovr_inc = start_i;
                // Abort wins over a capture or completion on the same edge.
                if (to_hit) begin
                    state_d      = ST_IDLE;
                    ch1_d.enable = 1'b0;
                    ch2_d.enable = 1'b0;
                    timeout_d    = 1'b1;
                    err_inc      = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (ch1_q.done && ch2_q.done) begin
                        state_d = ST_IDLE;
                        eoc_d   = 1'b1;
                    end else begin
                        if (adc1_ready_i && !ch1_q.done) begin
                            ch1_d.code   = adc_to_code(adc1_data_i);
                            ch1_d.enable = 1'b0;
                            ch1_d.done   = 1'b1;
                        end
                        if (adc2_ready_i && !ch2_q.done) begin
                            ch2_d.code   = adc_to_code(adc2_data_i);
                            ch2_d.enable = 1'b0;
                            ch2_d.done   = 1'b1;
                        end
                    end
                end
            end

            default: begin
                // Unused encoding: park safely with both converters off.
                state_d      = ST_IDLE;
                ch1_d.enable = 1'b0;
                ch2_d.enable = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Scheduler registers; every output comes straight from one of these.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            to_cnt_q  <= '0;
            ch1_q     <= '0;
            ch2_q     <= '0;
            eoc_q     <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            ch1_q     <= ch1_d;
            ch2_q     <= ch2_d;
            eoc_q     <= eoc_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    sat_cnt8 u_err_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (err_inc),
        .cnt_o  (err_cnt_o)
    );

    sat_cnt8 u_overrun_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (ovr_inc),
        .cnt_o  (overrun_cnt_o)
    );

    assign adc1_enable_o = ch1_q.enable;
    assign adc2_enable_o = ch2_q.enable;
    assign v_fc_o        = ch1_q.code;
    assign v_out_o       = ch2_q.code;
    assign eoc_o         = eoc_q;
    assign busy_o        = busy_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_adc_pair_sched.sv
// Directed bench for adc_pair_sched: a main instance with the default
// timeout and a second instance with a 100-cycle timeout.
module tb_adc_pair_sched;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_ni;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- main DUT ----------------
    logic        start, r1, r2, en1, en2, eoc, busy, tmo;
    logic [15:0] a1, a2;
    logic [11:0] v_fc, v_out;
    logic [7:0]  err_cnt, ovr_cnt;

    adc_pair_sched dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start),
        .adc1_ready_i  (r1),
        .adc1_data_i   (a1),
        .adc1_enable_o (en1),
        .adc2_ready_i  (r2),
        .adc2_data_i   (a2),
        .adc2_enable_o (en2),
        .v_fc_o        (v_fc),
        .v_out_o       (v_out),
        .eoc_o         (eoc),
        .busy_o        (busy),
        .timeout_o     (tmo),
        .err_cnt_o     (err_cnt),
        .overrun_cnt_o (ovr_cnt)
    );

    // ---------------- timeout DUT ----------------
    logic        start_t, r1_t, r2_t, en1_t, en2_t, eoc_t, busy_t, tmo_t;
    logic [15:0] a1_t, a2_t;
    logic [11:0] v_fc_t, v_out_t;
    logic [7:0]  err_t, ovr_t;

    adc_pair_sched #(.TIMEOUT_CYCLES(100)) dut_to (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start_t),
        .adc1_ready_i  (r1_t),
        .adc1_data_i   (a1_t),
        .adc1_enable_o (en1_t),
        .adc2_ready_i  (r2_t),
        .adc2_data_i   (a2_t),
        .adc2_enable_o (en2_t),
        .v_fc_o        (v_fc_t),
        .v_out_o       (v_out_t),
        .eoc_o         (eoc_t),
        .busy_o        (busy_t),
        .timeout_o     (tmo_t),
        .err_cnt_o     (err_t),
        .overrun_cnt_o (ovr_t)
    );

    // ---------------- scoreboard ----------------
    logic [23:0] exp_q[$];   // {v_fc, v_out} expected at each eoc of the main DUT
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every eoc pulse of the main DUT retires one expected result.
    always @(posedge clk) begin
        #2;
        if (eoc === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("eoc_unexpected", 32'd1, 32'd0);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk("sb_codes", {8'd0, v_fc, v_out}, {8'd0, e});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clean conversion on the main DUT; leaves the bench just after the eoc edge.
    task automatic run_normal(input logic [15:0] d1, input logic [15:0] d2, input logic [23:0] exp);
        exp_q.push_back(exp);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("norm_en1_on", en1, 1);
        chk("norm_en2_on", en2, 1);
        chk("norm_busy_on", busy, 1);
        tick(2);
        r1 = 1'b0;
        r2 = 1'b0;
        tick(40);
        a1 = d1;
        a2 = d2;
        r1 = 1'b1;
        r2 = 1'b1;
        tick(1);
        chk("norm_v_fc", v_fc, exp[23:12]);
        chk("norm_v_out", v_out, exp[11:0]);
        chk("norm_en1_off", en1, 0);
        chk("norm_en2_off", en2, 0);
        chk("norm_eoc_early", eoc, 0);
        chk("norm_busy_hold", busy, 1);
        tick(1);
        chk("norm_eoc", eoc, 1);
        chk("norm_busy_off", busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic seen_tmo;
        logic seen_eoc;

        rst_ni  = 1'b0;
        start   = 1'b0; r1 = 1'b1; r2 = 1'b1; a1 = '0; a2 = '0;
        start_t = 1'b0; r1_t = 1'b1; r2_t = 1'b1; a1_t = '0; a2_t = '0;
        tick(3);
        rst_ni = 1'b1;
        tick(1);

        // Reset state
        chk("rst_en1", en1, 0);
        chk("rst_en2", en2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_eoc", eoc, 0);
        chk("rst_v_fc", v_fc, 0);
        chk("rst_v_out", v_out, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_ovr", ovr_cnt, 0);

        // Timeout instance: one good conversion to set known codes
        start_t = 1'b1;
        tick(1);
        start_t = 1'b0;
        r1_t = 1'b0;
        r2_t = 1'b0;
        tick(3);
        a1_t = 16'h1234;
        a2_t = 16'h3000;
        r1_t = 1'b1;
        r2_t = 1'b1;
        tick(2);
        chk("to_pre_eoc", eoc_t, 1);
        chk("to_pre_v_fc", v_fc_t, 12'h246);
        chk("to_pre_v_out", v_out_t, 12'h600);
        tick(2);

        // Timeout: ADC2 never returns ready-high
        a1_t = 16'h0800;
        a2_t = 16'h7FFF;
        start_t = 1'b1;
        tick(1);                 // edge N
        start_t = 1'b0;
        r1_t = 1'b0;
        r2_t = 1'b0;
        tick(1);                 // N+1: CAPTURE
        r1_t = 1'b1;
        tick(1);                 // N+2: ADC1 captured
        seen_tmo = 1'b0;
        seen_eoc = 1'b0;
        for (int i = 3; i <= 99; i++) begin
            tick(1);
            seen_tmo = seen_tmo | tmo_t;
            seen_eoc = seen_eoc | eoc_t;
        end
        chk("to_no_early_pulse", seen_tmo, 0);
        chk("to_no_eoc_before", seen_eoc, 0);
        chk("to_busy_n99", busy_t, 1);
        chk("to_en1_n99", en1_t, 0);
        chk("to_en2_n99", en2_t, 1);
        tick(1);                 // N+100
        chk("to_pulse", tmo_t, 1);
        chk("to_en1", en1_t, 0);
        chk("to_en2", en2_t, 0);
        chk("to_busy", busy_t, 0);
        chk("to_err_cnt", err_t, 1);
        chk("to_eoc", eoc_t, 0);
        chk("to_v_fc_new", v_fc_t, 12'h100);
        chk("to_v_out_kept", v_out_t, 12'h600);
        tick(1);
        chk("to_pulse_single", tmo_t, 0);
        chk("to_eoc_after", eoc_t, 0);

        // Normal conversion
        run_normal(16'h1234, 16'h3000, {12'h246, 12'h600});

        // Start coinciding with eoc: accepted, not an overrun
        exp_q.push_back({12'hFFF, 12'h000});
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("eocstart_busy", busy, 1);
        chk("eocstart_en1", en1, 1);
        chk("eocstart_en2", en2, 1);
        chk("eocstart_ovr", ovr_cnt, 0);
        r1 = 1'b0;
        r2 = 1'b0;
        tick(3);
        a1 = 16'h7FFF;           // full scale
        a2 = 16'h0007;           // below one code step
        r1 = 1'b1;
        r2 = 1'b1;
        tick(2);
        chk("eocstart_busy_off", busy, 0);

        // Skewed readies, negative ADC1 data
        exp_q.push_back({12'h000, 12'hFFF});
        a1 = 16'h8001;
        a2 = 16'h7FFF;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        r1 = 1'b0;
        r2 = 1'b0;
        tick(3);
        r1 = 1'b1;
        tick(1);
        chk("skew_en1_off", en1, 0);
        chk("skew_en2_on", en2, 1);
        chk("skew_v_fc_clamp", v_fc, 12'h000);
        chk("skew_v_out_prev", v_out, 12'h000);
        a1 = 16'h4000;           // must not be recaptured
        tick(99);
        chk("skew_v_fc_hold", v_fc, 12'h000);
        chk("skew_busy", busy, 1);
        chk("skew_no_eoc", eoc, 0);
        r2 = 1'b1;
        tick(1);
        chk("skew_v_out", v_out, 12'hFFF);
        chk("skew_en2_off", en2, 0);
        tick(1);
        chk("skew_eoc", eoc, 1);
        chk("skew_busy_off", busy, 0);

        // Stale ready-high must not be captured
        exp_q.push_back({12'h002, 12'h1FF});
        a1 = 16'h0010;
        a2 = 16'h0FF8;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
        chk("stale_v_fc", v_fc, 12'h000);
        chk("stale_v_out", v_out, 12'hFFF);
        chk("stale_en1", en1, 1);
        chk("stale_en2", en2, 1);
        r1 = 1'b0;
        r2 = 1'b0;
        tick(5);
        r1 = 1'b1;
        r2 = 1'b1;
        tick(1);
        chk("stale_v_fc_cap", v_fc, 12'h002);
        chk("stale_v_out_cap", v_out, 12'h1FF);
        tick(1);
        chk("stale_busy_off", busy, 0);

        // Overrun saturation
        exp_q.push_back({12'h200, 12'h400});
        a1 = 16'h1000;
        a2 = 16'h2000;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        r1 = 1'b0;
        r2 = 1'b0;
        tick(1);
        for (int i = 0; i < 300; i++) begin
            start = 1'b1;
            tick(1);
            start = 1'b0;
            tick(1);
            if (i == 2) chk("ovr_cnt_3", ovr_cnt, 3);
        end
        chk("ovr_cnt_sat", ovr_cnt, 255);
        chk("ovr_busy", busy, 1);
        chk("ovr_en1", en1, 1);
        r1 = 1'b1;
        r2 = 1'b1;
        tick(2);
        chk("ovr_busy_off", busy, 0);
        chk("ovr_cnt_hold", ovr_cnt, 255);
        chk("ovr_err_zero", err_cnt, 0);

        // Asynchronous reset in the middle of CAPTURE
        start = 1'b1;
        tick(1);
        start = 1'b0;
        r1 = 1'b0;
        r2 = 1'b0;
        tick(3);
        a1 = 16'h1234;
        r1 = 1'b1;
        tick(1);
        chk("mid_pre_v_fc", v_fc, 12'h246);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("mid_v_fc", v_fc, 0);
        chk("mid_v_out", v_out, 0);
        chk("mid_en1", en1, 0);
        chk("mid_en2", en2, 0);
        chk("mid_busy", busy, 0);
        chk("mid_eoc", eoc, 0);
        chk("mid_tmo", tmo, 0);
        chk("mid_err", err_cnt, 0);
        chk("mid_ovr", ovr_cnt, 0);
        tick(1);
        rst_ni = 1'b1;
        r1 = 1'b1;
        r2 = 1'b1;
        tick(1);
        run_normal(16'h1234, 16'h3000, {12'h246, 12'h600});

        tick(3);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
